if_mem_fetch: RTL

Instruction-fetch memory front end that sits directly upstream of the IF stage. It receives the IF stage's fetch request and PC, reads the 32-bit instruction from the byte-wide RAM port in four sequential byte reads, and holds the assembled word in a tagged buffer. While the buffer tag matches the requested PC it presents the word with `ram_done` high; otherwise the IF stage stalls. An optional direct-mapped instruction cache removes RAM traffic on repeated PCs.

---
 rtl/if_mem_fetch.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/if_mem_fetch.sv
// if_mem_fetch: byte-serial instruction fetch front end with a one-word tagged buffer.
// Defining IF_ICACHE_EN adds a direct-mapped, one-word-per-line instruction cache.
module if_mem_fetch #(
   parameter int ICACHE_LINES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        flush,
   input  logic        ram_request,
   input  logic [31:0] pc_i,
   output logic        ram_done,
   output logic [31:0] inst_o,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_a,
   input  logic [7:0]  mem_din
);
   typedef enum logic [2:0] {IDLE, A1, A2, A3, LAST} state_t;

   state_t      state_q, state_d;
   logic        buf_valid_q, buf_valid_d;
   logic [29:0] buf_tag_q, buf_tag_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [29:0] fpc_q, fpc_d;
   logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic        mem_req_q;
   logic [31:0] mem_a_q;
   logic        hit, miss, abort, cache_hit, cache_we;
   logic [31:0] cache_word, fill_word;
   logic        unused_pc;

   generate
      if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
         $error("ICACHE_LINES must be a power of two, at least 2");
      end
   endgenerate

   assign unused_pc = ^pc_i[1:0];
   assign hit       = ram_request && buf_valid_q && (buf_tag_q == pc_i[31:2]);
   assign miss      = ram_request && !hit && !flush;
   assign abort     = (state_q != IDLE) && (pc_i[31:2] != fpc_q);
   assign ram_done  = hit;
   assign inst_o    = hit ? buf_inst_q : 32'h0;
   assign fill_word = {mem_din, b2_q, b1_q, b0_q};

`ifdef IF_ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [ICACHE_LINES-1:0] cvalid_q;
   logic [TAG_W-1:0]        ctag_q  [ICACHE_LINES];
   logic [31:0]             cdata_q [ICACHE_LINES];
   logic [IDX_W-1:0]        rd_idx, wr_idx;

   assign rd_idx     = pc_i[IDX_W+1:2];
   assign wr_idx     = fpc_q[IDX_W-1:0];
   assign cache_hit  = cvalid_q[rd_idx] && (ctag_q[rd_idx] == pc_i[31:IDX_W+2]);
   assign cache_word = cdata_q[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cvalid_q         <= '0;
      else if (rdy && cache_we) cvalid_q[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rdy && cache_we) begin
         ctag_q[wr_idx]  <= fpc_q[29:IDX_W];
         cdata_q[wr_idx] <= fill_word;
      end
   end
`else
   logic unused_cache;
   assign cache_hit    = 1'b0;
   assign cache_word   = 32'h0;
   assign unused_cache = cache_we;
`endif

   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_inst_d  = buf_inst_q;
      fpc_d       = fpc_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      b2_d        = b2_q;
      cache_we    = 1'b0;
      mem_req     = 1'b0;
      mem_a       = mem_a_q;
      case (state_q)
         IDLE: begin
            if (!rdy) begin
               mem_req = mem_req_q;
            end else if (miss && cache_hit) begin
               buf_valid_d = 1'b1;
               buf_tag_d   = pc_i[31:2];
               buf_inst_d  = cache_word;
            end else if (miss) begin
               mem_req = 1'b1;
               if (mem_gnt) begin
                  mem_a   = {pc_i[31:2], 2'b00};
                  fpc_d   = pc_i[31:2];
                  state_d = A1;
               end
            end
         end
         A1: begin
            mem_req = 1'b1;
            mem_a   = {fpc_q, 2'd1};
            b0_d    = mem_din;
            state_d = A2;
         end
         A2: begin
            mem_req = 1'b1;
            mem_a   = {fpc_q, 2'd2};
            b1_d    = mem_din;
            state_d = A3;
         end
         A3: begin
            mem_req = 1'b1;
            mem_a   = {fpc_q, 2'd3};
            b2_d    = mem_din;
            state_d = LAST;
         end
         LAST: begin
            state_d = IDLE;
            if (!abort && !flush) begin
               buf_valid_d = 1'b1;
               buf_tag_d   = fpc_q;
               buf_inst_d  = fill_word;
               cache_we    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A moved PC abandons the fetch; a redirect also drops the buffered word
      if (abort) state_d = IDLE;
      if (flush) begin
         state_d     = IDLE;
         buf_valid_d = 1'b0;
      end
      if (!rst_n) begin
         mem_req = 1'b0;
         mem_a   = 32'h0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         buf_valid_q <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_a_q     <= 32'h0;
      end else if (rdy) begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         mem_req_q   <= mem_req;
         mem_a_q     <= mem_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rdy) begin
         buf_tag_q  <= buf_tag_d;
         buf_inst_q <= buf_inst_d;
         fpc_q      <= fpc_d;
         b0_q       <= b0_d;
         b1_q       <= b1_d;
         b2_q       <= b2_d;
      end
   end
endmodule
